// File: rtl/nn_pkg.sv
// Shared constants for the small MLP datapath: word widths, buffer depth
// and the neuron count of each network layer.
package nn_pkg;

   localparam int DW = 16;
   localparam int DEPTH = 16;
   localparam int AW = $clog2(DEPTH);

   localparam int L0_SIZE = 13;
   localparam int L1_SIZE = 6;
   localparam int L2_SIZE = 3;

endpackage

// File: rtl/act_pingpong_buf_if.sv
// Write/read bundle of the activation ping-pong buffer.
// The producer/consumer side is master, the buffer is slave.
interface act_pingpong_buf_if #(
   parameter int DW = nn_pkg::DW,
   parameter int AW = nn_pkg::AW
);

   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_last;
   logic          wr_ready;

   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_release;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          bank_avail;
   logic [AW:0]   rd_len;
   logic          err;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_last,
      output rd_en, rd_addr, rd_release,
      input  wr_ready, rd_data, rd_valid,
      input  bank_avail, rd_len, err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_last,
      input  rd_en, rd_addr, rd_release,
      output wr_ready, rd_data, rd_valid,
      output bank_avail, rd_len, err
   );

endinterface

// File: rtl/act_relu_shift.sv
// Write-path activation: arithmetic right shift of the signed sum,
// then clamp negatives to zero.
module act_relu_shift #(
   parameter int DW = nn_pkg::DW,
   parameter int SHIFT = 0
) (
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic signed [DW-1:0] shifted;

   assign shifted = $signed(din) >>> SHIFT;
   assign dout = shifted[DW-1] ? '0 : shifted;

endmodule

// File: rtl/act_pingpong_buf.sv
// Two-bank activation buffer: one layer is written while the previous
// committed layer is read; banks hand over on commit/release.
module act_pingpong_buf #(
   parameter int DW = nn_pkg::DW,
   parameter int DEPTH = nn_pkg::DEPTH,
   parameter int SHIFT = 0
) (
   input logic               clk,
   input logic               rst,
   act_pingpong_buf_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem_q [2][DEPTH];

   logic [1:0]    full_q, full_d;
   logic [LW-1:0] len_q [2];
   logic [LW-1:0] len_d [2];
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic          rd_valid_q, rd_valid_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          err_q, err_d;

   logic [DW-1:0] act;
   logic          wr_ready;
   logic          bank_avail;
   logic          wr_fire;
   logic          rd_fire;
   logic          rel_fire;
   logic          in_range;

   act_relu_shift #(
      .DW    (DW),
      .SHIFT (SHIFT)
   ) u_relu (
      .din  (bus.wr_data),
      .dout (act)
   );

   assign wr_ready   = !full_q[wr_bank_q];
   assign bank_avail = full_q[rd_bank_q];
   assign wr_fire    = bus.wr_valid && wr_ready;
   assign rd_fire    = bus.rd_en && bank_avail;
   assign rel_fire   = bus.rd_release && bank_avail;
   assign in_range   = LW'(bus.rd_addr) < len_q[rd_bank_q];

   // Commit and release never hit the same bank, so both may apply.
   always_comb begin
      full_d     = full_q;
      len_d      = len_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      rd_valid_d = rd_fire;
      rd_data_d  = rd_data_q;
      err_d      = err_q;

      if (wr_fire && bus.wr_last) begin
         full_d[wr_bank_q] = 1'b1;
         len_d[wr_bank_q]  = LW'(bus.wr_addr) + LW'(1);
         wr_bank_d         = !wr_bank_q;
      end

      if (rel_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end

      if (rd_fire) begin
         rd_data_d = in_range ? mem_q[rd_bank_q][bus.rd_addr] : '0;
      end

      if ((bus.wr_valid && !wr_ready) ||
          (bus.rd_en && !bank_avail) ||
          (bus.rd_release && !bank_avail)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= '0;
         len_q      <= '{default: '0};
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         full_q     <= full_d;
         len_q      <= len_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
      end
   end

   // Storage is not reset; stale entries are masked by len on read.
   always_ff @(posedge clk) begin
      if (wr_fire && !rst) begin
         mem_q[wr_bank_q][bus.wr_addr] <= act;
      end
   end

   assign bus.wr_ready   = wr_ready;
   assign bus.bank_avail = bank_avail;
   assign bus.rd_len     = bank_avail ? len_q[rd_bank_q] : '0;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_act_pingpong_buf.sv
// Bench for act_pingpong_buf: directed scenarios plus random traffic,
// compared against a layer-queue reference model.
module tb_act_pingpong_buf;
   import nn_pkg::*;

   typedef struct {
      logic [DW-1:0] d [DEPTH];
      int            len;
   } layer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   act_pingpong_buf_if #(.DW(DW), .AW(AW)) b0 ();
   act_pingpong_buf_if #(.DW(DW), .AW(AW)) b2 ();

   act_pingpong_buf #(.DW(DW), .DEPTH(DEPTH), .SHIFT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   act_pingpong_buf #(.DW(DW), .DEPTH(DEPTH), .SHIFT(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (b2)
   );

   int checks = 0;
   int errors = 0;

   // Committed layers in commit order; front is what the reader sees.
   layer_t        q[$];
   layer_t        part;
   logic [DW-1:0] e_rd;
   logic          e_rv;
   logic          e_err;

   logic [DW-1:0] d31 [6];
   logic [DW-1:0] x31 [6];
   logic [DW-1:0] held;
   int            ptr;
   int            llen;
   bit            w;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu(logic [DW-1:0] v, int sh);
      int s;
      s = int'($signed(v));
      s = s >>> sh;
      return (s < 0) ? '0 : DW'(s);
   endfunction

   task automatic model_step();
      bit avail;
      bit ready;
      avail = q.size() > 0;
      ready = q.size() < 2;
      if (rst) begin
         q.delete();
         e_rv  = 1'b0;
         e_rd  = '0;
         e_err = 1'b0;
         return;
      end
      e_rv = 1'b0;
      if (b0.rd_en) begin
         if (avail) begin
            e_rv = 1'b1;
            e_rd = (int'(b0.rd_addr) < q[0].len) ? q[0].d[b0.rd_addr] : '0;
         end else begin
            e_err = 1'b1;
         end
      end
      if (b0.rd_release) begin
         if (avail) void'(q.pop_front());
         else e_err = 1'b1;
      end
      if (b0.wr_valid) begin
         if (ready) begin
            part.d[b0.wr_addr] = relu(b0.wr_data, 0);
            if (b0.wr_last) begin
               part.len = int'(b0.wr_addr) + 1;
               q.push_back(part);
            end
         end else begin
            e_err = 1'b1;
         end
      end
   endtask

   task automatic tick();
      int exp_len;
      @(posedge clk);
      model_step();
      #1;
      exp_len = (q.size() > 0) ? q[0].len : 0;
      chk("rd_valid", 32'(b0.rd_valid), 32'(e_rv));
      chk("rd_data", 32'(b0.rd_data), 32'(e_rd));
      chk("err", 32'(b0.err), 32'(e_err));
      chk("wr_ready", 32'(b0.wr_ready), 32'(q.size() < 2));
      chk("bank_avail", 32'(b0.bank_avail), 32'(q.size() > 0));
      chk("rd_len", 32'(b0.rd_len), 32'(exp_len));
   endtask

   task automatic wr(int addr, logic [DW-1:0] data, bit last, bit rel = 1'b0);
      b0.wr_valid   = 1'b1;
      b0.wr_addr    = AW'(addr);
      b0.wr_data    = data;
      b0.wr_last    = last;
      b0.rd_release = rel;
      tick();
      b0.wr_valid   = 1'b0;
      b0.wr_last    = 1'b0;
      b0.rd_release = 1'b0;
   endtask

   task automatic rd(int addr);
      b0.rd_en   = 1'b1;
      b0.rd_addr = AW'(addr);
      tick();
      b0.rd_en   = 1'b0;
   endtask

   task automatic rel();
      b0.rd_release = 1'b1;
      tick();
      b0.rd_release = 1'b0;
   endtask

   task automatic fill(int n);
      for (int i = 0; i < n; i++) begin
         wr(i, DW'($urandom), i == n - 1);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      d31 = '{16'd5, 16'hFFFD, 16'd100, 16'd0, 16'h8000, 16'h7FFF};
      x31 = '{16'd5, 16'd0, 16'd100, 16'd0, 16'd0, 16'd32767};
      {b0.wr_valid, b0.wr_last, b0.rd_en, b0.rd_release} = '0;
      {b0.wr_addr, b0.rd_addr, b0.wr_data} = '0;
      {b2.wr_valid, b2.wr_last, b2.rd_en, b2.rd_release} = '0;
      {b2.wr_addr, b2.rd_addr, b2.wr_data} = '0;

      reset_dut();
      chk("rst_wr_ready", 32'(b0.wr_ready), 32'd1);
      chk("rst_bank_avail", 32'(b0.bank_avail), 32'd0);
      chk("rst_err", 32'(b0.err), 32'd0);

      // Shift-by-2 instance
      b2.wr_valid = 1'b1;
      b2.wr_addr  = 4'd0;
      b2.wr_data  = 16'h0013;
      @(posedge clk); #1;
      b2.wr_addr  = 4'd1;
      b2.wr_data  = 16'hFFF0;
      b2.wr_last  = 1'b1;
      @(posedge clk); #1;
      b2.wr_valid = 1'b0;
      b2.wr_last  = 1'b0;
      chk("s2_avail", 32'(b2.bank_avail), 32'd1);
      chk("s2_len", 32'(b2.rd_len), 32'd2);
      b2.rd_en    = 1'b1;
      b2.rd_addr  = 4'd0;
      @(posedge clk); #1;
      chk("s2_rd0", 32'(b2.rd_data), 32'd4);
      b2.rd_addr  = 4'd1;
      @(posedge clk); #1;
      b2.rd_en    = 1'b0;
      chk("s2_rd1", 32'(b2.rd_data), 32'd0);
      chk("s2_rv", 32'(b2.rd_valid), 32'd1);

      // Signed sums through ReLU, one six-entry layer
      for (int i = 0; i < L1_SIZE; i++) wr(i, d31[i], i == L1_SIZE - 1);
      chk("l6_avail", 32'(b0.bank_avail), 32'd1);
      chk("l6_len", 32'(b0.rd_len), 32'd6);
      for (int i = 0; i < L1_SIZE; i++) begin
         rd(i);
         chk("l6_data", 32'(b0.rd_data), 32'(x31[i]));
         chk("l6_rv", 32'(b0.rd_valid), 32'd1);
      end

      // Both banks committed, then hand-over
      fill(L2_SIZE);
      chk("both_full_ready", 32'(b0.wr_ready), 32'd0);
      rel();
      chk("rel_len", 32'(b0.rd_len), 32'd3);
      chk("rel_ready", 32'(b0.wr_ready), 32'd1);
      rd(7);
      chk("pad_data", 32'(b0.rd_data), 32'd0);
      chk("pad_rv", 32'(b0.rd_valid), 32'd1);
      chk("pad_err", 32'(b0.err), 32'd0);
      fill(2);
      chk("full2_ready", 32'(b0.wr_ready), 32'd0);
      wr(0, 16'd1234, 1'b0);
      chk("ovf_err", 32'(b0.err), 32'd1);
      rd(1);
      held = e_rd;
      rel();
      rel();
      chk("empty_avail", 32'(b0.bank_avail), 32'd0);
      rd(3);
      chk("noavail_rv", 32'(b0.rd_valid), 32'd0);
      chk("noavail_hold", 32'(b0.rd_data), 32'(held));
      rel();
      chk("sticky_err", 32'(b0.err), 32'd1);

      // Commit and release in one cycle
      reset_dut();
      fill(1);
      for (int i = 0; i < 4; i++) wr(i, DW'($urandom), i == 3, i == 3);
      chk("cr_avail", 32'(b0.bank_avail), 32'd1);
      chk("cr_len", 32'(b0.rd_len), 32'd4);
      chk("cr_ready", 32'(b0.wr_ready), 32'd1);
      for (int i = 0; i < 4; i++) rd(i);

      // Mid-layer reset, racing a final write
      reset_dut();
      for (int i = 0; i < 3; i++) wr(i, DW'($urandom), 1'b0);
      rst = 1'b1;
      wr(3, 16'd77, 1'b1);
      rst = 1'b0;
      chk("mid_avail", 32'(b0.bank_avail), 32'd0);
      chk("mid_ready", 32'(b0.wr_ready), 32'd1);
      chk("mid_err", 32'(b0.err), 32'd0);
      fill(L0_SIZE);
      chk("l13_len", 32'(b0.rd_len), 32'd13);
      for (int i = 0; i < L0_SIZE; i += 4) rd(i);

      // Random traffic within protocol
      reset_dut();
      ptr  = 0;
      llen = $urandom_range(1, DEPTH);
      for (int c = 0; c < 800; c++) begin
         w = (q.size() < 2) && ($urandom_range(0, 3) != 0);
         b0.wr_valid   = w;
         b0.wr_addr    = AW'(ptr);
         b0.wr_data    = DW'($urandom);
         b0.wr_last    = (ptr == llen - 1);
         b0.rd_en      = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         b0.rd_addr    = AW'($urandom_range(0, DEPTH - 1));
         b0.rd_release = (q.size() > 0) && ($urandom_range(0, 7) == 0);
         tick();
         if (w) begin
            if (ptr == llen - 1) begin
               ptr  = 0;
               llen = $urandom_range(1, DEPTH);
            end else begin
               ptr++;
            end
         end
      end
      {b0.wr_valid, b0.wr_last, b0.rd_en, b0.rd_release} = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/act_pingpong_buf.md
ACT_PINGPONG_BUF -- requirements
Module: act_pingpong_buf

Interface
REQ-001 SHALL have parameter DW, 16, width of accumulator sums and stored activations.
REQ-002 SHALL have parameter DEPTH, 16, entries per bank; address width AW = log2(DEPTH) = 4.
REQ-003 SHALL have parameter SHIFT, 0, arithmetic right shift applied to write data before ReLU.
REQ-004 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports wr_valid in 1 (write request), wr_addr in AW (neuron index), wr_data in DW (signed sum), wr_last in 1 (final neuron of layer, commits bank).
REQ-007 SHALL have port wr_ready  out  1  current write bank accepts data.
REQ-008 SHALL have ports rd_en in 1 (read request), rd_addr in AW (activation index), rd_release in 1 (reader done with bank).
REQ-009 SHALL have ports rd_data out DW (activation), rd_valid out 1 (rd_data valid), bank_avail out 1 (committed bank readable), rd_len out AW+1 (entry count of read bank), err out 1 (sticky protocol error).

Function
REQ-010 SHALL hold two banks of DEPTH x DW storage, plus per bank a full flag and a length register (AW+1 bits).
REQ-011 SHALL hold registered pointers wr_bank and rd_bank, each 1 bit.
REQ-012 SHALL drive wr_ready = !full[wr_bank], combinational from registered state only, with no same-cycle bypass from rd_release.
REQ-013 SHALL accept a write when wr_valid && wr_ready, storing act = max(0, wr_data >>> SHIFT) at mem[wr_bank][wr_addr].
REQ-014 SHALL, on an accepted write with wr_last=1, set full[wr_bank]=1, set len[wr_bank]=wr_addr+1 and toggle wr_bank, all in the same cycle.
REQ-015 SHALL treat wr_valid while wr_ready=0 as no write: storage unchanged and err set.
REQ-016 SHALL drive bank_avail = full[rd_bank] and rd_len = len[rd_bank] when bank_avail, else 0.
REQ-017 SHALL have read latency 1: rd_en && bank_avail in cycle N gives rd_valid=1 in N+1 with rd_data = mem[rd_bank][rd_addr].
REQ-018 SHALL, for rd_addr >= len[rd_bank], return rd_data=0 with rd_valid=1 (zero padding) and leave err unchanged.
REQ-019 SHALL treat rd_en with bank_avail=0 as follows: rd_valid=0 next cycle, rd_data holds its previous value, err set.
REQ-020 SHALL, on rd_release && bank_avail, clear full[rd_bank] and toggle rd_bank; rd_release with bank_avail=0 is ignored and sets err.
REQ-021 SHALL, when rd_en and rd_release occur in the same cycle, read from the pre-toggle bank.
REQ-022 SHALL allow a commit (REQ-014) and a release (REQ-020) in the same cycle; they always target different banks, and both take effect.
REQ-023 SHALL keep rd_valid low in any cycle not following an accepted read.
REQ-024 SHALL keep err sticky until reset.

Reset
REQ-025 SHALL, on rst=1, clear full[1:0], len[1:0], wr_bank, rd_bank, rd_valid, rd_data and err, leaving storage contents undefined.
REQ-026 SHALL let a mid-layer rst discard partial writes and committed banks; the first cycle after reset gives wr_ready=1 and bank_avail=0.
REQ-027 SHALL give rst priority over any simultaneous write, read or release.

Structure
REQ-028 SHALL place DW, DEPTH, AW and the network layer sizes (13, 6, 3) as constants in the shared nn_pkg package.
REQ-029 SHALL contain one sub-module, act_relu_shift: a combinational shift plus ReLU unit instantiated on the write path.
REQ-030 SHALL be sized at 120-400 RTL lines with no other sub-modules.

Verification
REQ-031 SHALL pass: write addr 0..5 with data {5,-3,100,0,-32768,32767} and last on addr 5 -> bank_avail=1, rd_len=6, reads return {5,0,100,0,0,32767} one cycle after each rd_en.
REQ-032 SHALL pass: with SHIFT=2, write 0x0013 and 0xFFF0 -> reads return 4 and 0.
REQ-033 SHALL pass: commit bank 0 (6 entries), then commit bank 1 (3 entries) without release -> wr_ready=0; a further wr_valid sets err; rd_release -> reader sees rd_len=3 and wr_ready=1 the next cycle.
REQ-034 SHALL pass: with rd_len=3, rd_addr=7 -> rd_data=0, rd_valid=1, err=0; rd_en with bank_avail=0 -> rd_valid=0, err=1.
REQ-035 SHALL pass: commit and release in the same cycle -> both full flags and both pointers update correctly, with no lost bank.
REQ-036 SHALL pass: rst asserted after 3 of 6 writes -> bank_avail=0, wr_ready=1, err=0; a fresh 13-entry layer then commits with rd_len=13.
